// File: rtl/xmit_prio_sched.sv
// ---------------------------------------------------------------------------
// xmit_prio_sched
//
// Transmit frame scheduler. Pops one 24-bit control word from the
// high- or low-priority control FIFO, checks the frame length, and
// either starts the PHY transmitter or drops the frame. After each
// transmitted frame it holds off for an inter-frame gap.
//
// Control word: [11:0] length in bytes, [23:12] copy of the length.
// A frame is accepted when the copy matches and MIN_LEN <= len <= MAX_LEN.
//
// Optional feature macro: STARVE_GUARD_EN
//   Defined     : after HI_BURST_MAX consecutive hi grants, a pending lo
//                 frame is granted ahead of hi.
//   Not defined : strict priority, hi always wins.
//
// Ports
//   clk_sys        in   system clock
//   reset          in   asynchronous active-high reset
//   hi_ctrl_valid  in   hi control FIFO non-empty (show-ahead)
//   hi_ctrl_in     in   hi control word at FIFO head
//   hi_ctrl_rd     out  pop hi control FIFO
//   lo_ctrl_valid  in   lo control FIFO non-empty (show-ahead)
//   lo_ctrl_in     in   lo control word at FIFO head
//   lo_ctrl_rd     out  pop lo control FIFO
//   tx_done        in   transmitter finished the current frame (pulse)
//   tx_start       out  start pulse for the granted frame
//   tx_sel         out  queue of the granted frame (1 = hi), held
//   tx_len         out  byte length of the granted frame, held
//   discard_en     out  pulse: popped frame was dropped
//   discard_sel    out  queue of the dropped frame
//   sched_busy     out  high whenever the scheduler is not idle
// ---------------------------------------------------------------------------
module xmit_prio_sched #(
   parameter logic [11:0] MAX_LEN      = 12'd1518,
   parameter logic [11:0] MIN_LEN      = 12'd64,
   parameter int          IFG_CYCLES   = 12,
   parameter int          HI_BURST_MAX = 4
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        hi_ctrl_valid,
   input  logic [23:0] hi_ctrl_in,
   output logic        hi_ctrl_rd,
   input  logic        lo_ctrl_valid,
   input  logic [23:0] lo_ctrl_in,
   output logic        lo_ctrl_rd,
   input  logic        tx_done,
   output logic        tx_start,
   output logic        tx_sel,
   output logic [11:0] tx_len,
   output logic        discard_en,
   output logic        discard_sel,
   output logic        sched_busy
);

   if (HI_BURST_MAX < 1 || IFG_CYCLES < 0 || MIN_LEN > MAX_LEN) begin : g_param_check
      $error("xmit_prio_sched: illegal parameter combination");
   end

   typedef enum logic [1:0] {IDLE, CHECK, XMIT, IFG} state_t;

   state_t      state_q, state_d;
   logic [23:0] ctrl_q, ctrl_d;
   logic        sel_q, sel_d;
   logic [15:0] ifg_cnt_q, ifg_cnt_d;
   logic        tx_start_q, tx_start_d;
   logic        tx_sel_q, tx_sel_d;
   logic [11:0] tx_len_q, tx_len_d;
   logic        discard_en_q, discard_en_d;
   logic        discard_sel_q, discard_sel_d;
   logic        grant_hi, grant_lo;
   logic        frame_ok;

`ifdef STARVE_GUARD_EN
   logic [7:0]  burst_q, burst_d;
   logic        force_lo;

   assign force_lo = (burst_q == 8'(HI_BURST_MAX)) && lo_ctrl_valid;
`endif

   // Grant decision is combinational so the pop and the latch of the
   // head word happen on the same clock edge.
   always_comb begin
      grant_hi = 1'b0;
      grant_lo = 1'b0;
      if (state_q == IDLE) begin
`ifdef STARVE_GUARD_EN
         if (lo_ctrl_valid && (force_lo || !hi_ctrl_valid)) begin
            grant_lo = 1'b1;
         end else if (hi_ctrl_valid) begin
            grant_hi = 1'b1;
         end
`else
         if (hi_ctrl_valid) begin
            grant_hi = 1'b1;
         end else if (lo_ctrl_valid) begin
            grant_lo = 1'b1;
         end
`endif
      end
   end

   assign frame_ok = (ctrl_q[23:12] == ctrl_q[11:0]) &&
                     (ctrl_q[11:0] >= MIN_LEN) && (ctrl_q[11:0] <= MAX_LEN);

   always_comb begin
      state_d       = state_q;
      ctrl_d        = ctrl_q;
      sel_d         = sel_q;
      ifg_cnt_d     = ifg_cnt_q;
      tx_start_d    = 1'b0;
      tx_sel_d      = tx_sel_q;
      tx_len_d      = tx_len_q;
      discard_en_d  = 1'b0;
      discard_sel_d = discard_sel_q;
      case (state_q)
         IDLE: begin
            if (grant_hi || grant_lo) begin
               ctrl_d  = grant_hi ? hi_ctrl_in : lo_ctrl_in;
               sel_d   = grant_hi;
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (frame_ok) begin
               tx_start_d = 1'b1;
               tx_sel_d   = sel_q;
               tx_len_d   = ctrl_q[11:0];
               state_d    = XMIT;
            end else begin
               discard_en_d  = 1'b1;
               discard_sel_d = sel_q;
               state_d       = IDLE;
            end
         end
         XMIT: begin
            if (tx_done) begin
               if (IFG_CYCLES > 0) begin
                  ifg_cnt_d = 16'(IFG_CYCLES - 1);
                  state_d   = IFG;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         IFG: begin
            // Counter runs IFG_CYCLES-1 .. 0, giving exactly IFG_CYCLES gap cycles.
            if (ifg_cnt_q == 16'd0) begin
               state_d = IDLE;
            end else begin
               ifg_cnt_d = ifg_cnt_q - 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef STARVE_GUARD_EN
   // Discarded frames were popped too, so they count as grants here.
   always_comb begin
      burst_d = burst_q;
      if (grant_lo) begin
         burst_d = 8'd0;
      end else if (grant_hi && (burst_q != 8'(HI_BURST_MAX))) begin
         burst_d = burst_q + 8'd1;
      end
   end
`endif

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         ctrl_q        <= 24'd0;
         sel_q         <= 1'b0;
         ifg_cnt_q     <= 16'd0;
         tx_start_q    <= 1'b0;
         tx_sel_q      <= 1'b0;
         tx_len_q      <= 12'd0;
         discard_en_q  <= 1'b0;
         discard_sel_q <= 1'b0;
`ifdef STARVE_GUARD_EN
         burst_q       <= 8'd0;
`endif
      end else begin
         state_q       <= state_d;
         ctrl_q        <= ctrl_d;
         sel_q         <= sel_d;
         ifg_cnt_q     <= ifg_cnt_d;
         tx_start_q    <= tx_start_d;
         tx_sel_q      <= tx_sel_d;
         tx_len_q      <= tx_len_d;
         discard_en_q  <= discard_en_d;
         discard_sel_q <= discard_sel_d;
`ifdef STARVE_GUARD_EN
         burst_q       <= burst_d;
`endif
      end
   end

   // Pops are masked while reset is asserted so every output reads 0 then.
   assign hi_ctrl_rd  = grant_hi && !reset;
   assign lo_ctrl_rd  = grant_lo && !reset;
   assign tx_start    = tx_start_q;
   assign tx_sel      = tx_sel_q;
   assign tx_len      = tx_len_q;
   assign discard_en  = discard_en_q;
   assign discard_sel = discard_sel_q;
   assign sched_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_xmit_prio_sched.sv
module tb_xmit_prio_sched;

   localparam int IFG = 12;
   localparam int HBM = 4;

   logic        clk_sys       = 1'b0;
   logic        reset         = 1'b1;
   logic        hi_ctrl_valid = 1'b0;
   logic [23:0] hi_ctrl_in    = 24'd0;
   logic        hi_ctrl_rd;
   logic        lo_ctrl_valid = 1'b0;
   logic [23:0] lo_ctrl_in    = 24'd0;
   logic        lo_ctrl_rd;
   logic        tx_done       = 1'b0;
   logic        tx_start;
   logic        tx_sel;
   logic [11:0] tx_len;
   logic        discard_en;
   logic        discard_sel;
   logic        sched_busy;

   xmit_prio_sched #(
      .MAX_LEN(12'd1518), .MIN_LEN(12'd64), .IFG_CYCLES(IFG), .HI_BURST_MAX(HBM)
   ) dut (
      .clk_sys(clk_sys), .reset(reset),
      .hi_ctrl_valid(hi_ctrl_valid), .hi_ctrl_in(hi_ctrl_in), .hi_ctrl_rd(hi_ctrl_rd),
      .lo_ctrl_valid(lo_ctrl_valid), .lo_ctrl_in(lo_ctrl_in), .lo_ctrl_rd(lo_ctrl_rd),
      .tx_done(tx_done), .tx_start(tx_start), .tx_sel(tx_sel), .tx_len(tx_len),
      .discard_en(discard_en), .discard_sel(discard_sel), .sched_busy(sched_busy)
   );

   always #5 clk_sys = ~clk_sys;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Environment: two show-ahead FIFOs as queues.
   logic [23:0] hi_q[$];
   logic [23:0] lo_q[$];
   bit pop_hi = 0, pop_lo = 0;
   bit rand_mode = 0, rand_done = 0, force_done = 0;
   bit en_hi = 1, en_lo = 1;

   function automatic logic [23:0] rand_word();
      logic [11:0] l;
      case ($urandom_range(0, 6))
         0, 1, 2: begin l = 12'($urandom_range(64, 1518)); return {l, l}; end
         3: begin l = 12'($urandom_range(64, 1518)); return {l + 12'd1, l}; end
         4: begin l = 12'($urandom_range(0, 63)); return {l, l}; end
         5: begin l = 12'($urandom_range(1519, 4095)); return {l, l}; end
         default: begin
            case ($urandom_range(0, 3))
               0: l = 12'd63;
               1: l = 12'd64;
               2: l = 12'd1518;
               default: l = 12'd1519;
            endcase
            return {l, l};
         end
      endcase
   endfunction

   task automatic cyc();
      @(posedge clk_sys);
      #1;
      if (pop_hi && hi_q.size() > 0) void'(hi_q.pop_front());
      if (pop_lo && lo_q.size() > 0) void'(lo_q.pop_front());
      if (rand_mode) begin
         if (hi_q.size() < 3 && $urandom_range(0, 3) == 0) hi_q.push_back(rand_word());
         if (lo_q.size() < 3 && $urandom_range(0, 3) == 0) lo_q.push_back(rand_word());
         en_hi = ($urandom_range(0, 4) != 0);
         en_lo = ($urandom_range(0, 4) != 0);
      end else begin
         en_hi = 1;
         en_lo = 1;
      end
      hi_ctrl_valid = en_hi && (hi_q.size() > 0);
      hi_ctrl_in    = (hi_q.size() > 0) ? hi_q[0] : 24'd0;
      lo_ctrl_valid = en_lo && (lo_q.size() > 0);
      lo_ctrl_in    = (lo_q.size() > 0) ? lo_q[0] : 24'd0;
      tx_done       = force_done || (rand_done && ($urandom_range(0, 5) == 0));
      #1;
   endtask

   // ---------------- behavioural reference model ----------------
   // Tracks event timestamps (last pop, end of gap) instead of states.
   function automatic bit fv(input logic [23:0] w);
      int len;
      len = int'(w[11:0]);
      return (w[23:12] == w[11:0]) && (len >= 64) && (len <= 1518);
   endfunction

   int          mc = 0;
   int          g_cyc = -100;
   int          gap_end = -1;
   logic [23:0] g_word = 24'd0;
   bit          g_hi = 0;
   bit          m_xmit = 0;
   int          m_burst = 0;
   bit          e_sel = 0, e_dsel = 0;
   logic [11:0] e_len = 12'd0;
   bit          e_start, e_disc, e_h, e_l, m_idle;

   always @(negedge clk_sys) begin
      mc++;
      if (reset) begin
         chk("rst_hi_rd", hi_ctrl_rd, 0);
         chk("rst_lo_rd", lo_ctrl_rd, 0);
         chk("rst_tx_start", tx_start, 0);
         chk("rst_tx_sel", tx_sel, 0);
         chk("rst_tx_len", tx_len, 0);
         chk("rst_discard_en", discard_en, 0);
         chk("rst_discard_sel", discard_sel, 0);
         chk("rst_busy", sched_busy, 0);
         g_cyc = -100; gap_end = -1; g_word = 24'd0; g_hi = 0; m_xmit = 0;
         m_burst = 0; e_sel = 0; e_dsel = 0; e_len = 12'd0;
         pop_hi = 0; pop_lo = 0;
      end else begin
         e_start = (mc == g_cyc + 2) && fv(g_word);
         e_disc  = (mc == g_cyc + 2) && !fv(g_word);
         if (e_start) begin
            m_xmit = 1; e_sel = g_hi; e_len = g_word[11:0];
         end
         if (e_disc) e_dsel = g_hi;
         m_idle = (mc != g_cyc + 1) && !m_xmit && (mc > gap_end);
         e_h = 0; e_l = 0;
         if (m_idle) begin
`ifdef STARVE_GUARD_EN
            if (lo_ctrl_valid && (m_burst == HBM || !hi_ctrl_valid)) e_l = 1;
            else if (hi_ctrl_valid) e_h = 1;
`else
            if (hi_ctrl_valid) e_h = 1;
            else if (lo_ctrl_valid) e_l = 1;
`endif
         end
         chk("hi_ctrl_rd", hi_ctrl_rd, e_h);
         chk("lo_ctrl_rd", lo_ctrl_rd, e_l);
         chk("tx_start", tx_start, e_start);
         chk("tx_sel", tx_sel, e_sel);
         chk("tx_len", tx_len, e_len);
         chk("discard_en", discard_en, e_disc);
         chk("discard_sel", discard_sel, e_dsel);
         chk("sched_busy", sched_busy, !m_idle);
         pop_hi = hi_ctrl_rd;
         pop_lo = lo_ctrl_rd;
         if (e_h || e_l) begin
            g_cyc  = mc;
            g_word = e_h ? hi_ctrl_in : lo_ctrl_in;
            g_hi   = e_h;
            if (e_l) m_burst = 0;
            else if (m_burst < HBM) m_burst++;
         end
         if (m_xmit && tx_done) begin
            m_xmit  = 0;
            gap_end = mc + IFG;
         end
      end
   end

   // ---------------- directed + random stimulus ----------------
   task automatic finish_frame(input string nm, input int exp_gap);
      int n;
      n = 0;
      force_done = 1;
      cyc();
      force_done = 0;
      for (int i = 0; i < 100; i++) begin
         cyc();
         if (!sched_busy) break;
         n++;
      end
      chk(nm, n, exp_gap);
   endtask

   logic [23:0] bad_words[3] = '{24'h200100, 24'h03F03F, 24'h7FF7FF};
   bit          order[10];
   int          ng;

   initial begin
      repeat (3) cyc();
      chk("reset_busy", sched_busy, 0);
      chk("reset_tx_start", tx_start, 0);
      chk("reset_tx_len", tx_len, 0);
      reset = 0;

      // Single lo frame
      lo_q.push_back(24'h200200);
      cyc();
      chk("t1_lo_rd", lo_ctrl_rd, 1);
      chk("t1_hi_rd", hi_ctrl_rd, 0);
      cyc();
      chk("t1_no_start_in_check", tx_start, 0);
      cyc();
      chk("t1_tx_start", tx_start, 1);
      chk("t1_tx_sel", tx_sel, 0);
      chk("t1_tx_len", tx_len, 12'h200);
      cyc();
      chk("t1_start_pulse", tx_start, 0);
      finish_frame("t1_gap_len", IFG);

      // Both pending: hi first, then lo
      hi_q.push_back(24'h040040);
      lo_q.push_back(24'h040040);
      cyc();
      chk("t2_hi_rd", hi_ctrl_rd, 1);
      chk("t2_lo_rd", lo_ctrl_rd, 0);
      cyc(); cyc();
      chk("t2_tx_start", tx_start, 1);
      chk("t2_tx_sel_hi", tx_sel, 1);
      chk("t2_tx_len", tx_len, 12'h040);
      finish_frame("t2_gap_hi", IFG);
      chk("t2_lo_rd_after_gap", lo_ctrl_rd, 1);
      cyc(); cyc();
      chk("t2_tx_start_lo", tx_start, 1);
      chk("t2_tx_sel_lo", tx_sel, 0);
      finish_frame("t2_gap_lo", IFG);

      // Invalid words on both queues
      for (int q = 0; q < 2; q++) begin
         for (int k = 0; k < 3; k++) begin
            if (q == 1) hi_q.push_back(bad_words[k]);
            else lo_q.push_back(bad_words[k]);
            cyc();
            chk("t3_rd", (q == 1) ? hi_ctrl_rd : lo_ctrl_rd, 1);
            cyc(); cyc();
            chk("t3_discard_en", discard_en, 1);
            chk("t3_discard_sel", discard_sel, q);
            chk("t3_no_start", tx_start, 0);
            chk("t3_idle", sched_busy, 0);
            cyc();
            chk("t3_discard_pulse", discard_en, 0);
         end
      end

      // tx_done in IDLE and CHECK is ignored
      hi_q.push_back(24'h100100);
      force_done = 1;
      cyc();
      chk("t4_hi_rd", hi_ctrl_rd, 1);
      cyc();
      force_done = 0;
      cyc();
      chk("t4_tx_start", tx_start, 1);
      repeat (15) cyc();
      chk("t4_still_xmit", sched_busy, 1);
      finish_frame("t4_gap", IFG);

      // Reset three cycles into XMIT
      hi_q.push_back(24'h200200);
      cyc(); cyc(); cyc();
      chk("t5_tx_start", tx_start, 1);
      lo_q.push_back(24'h080080);
      cyc(); cyc();
      reset = 1;
      #1;
      chk("t5_rst_busy", sched_busy, 0);
      chk("t5_rst_tx_sel", tx_sel, 0);
      chk("t5_rst_tx_len", tx_len, 0);
      chk("t5_rst_lo_rd", lo_ctrl_rd, 0);
      cyc();
      reset = 0;
      #1;
      chk("t5_lo_rd_after_rst", lo_ctrl_rd, 1);
      cyc(); cyc();
      chk("t5_tx_start_lo", tx_start, 1);
      chk("t5_tx_len_lo", tx_len, 12'h080);
      finish_frame("t5_gap", IFG);

      // Randomized traffic
      rand_mode = 1;
      rand_done = 1;
      for (int i = 0; i < 3000; i++) cyc();
      rand_mode = 0;
      for (int i = 0; i < 3000; i++) begin
         cyc();
         if (hi_q.size() == 0 && lo_q.size() == 0 && !sched_busy) break;
      end
      rand_done = 0;
      chk("drain_done", hi_q.size() + lo_q.size() + int'(sched_busy), 0);

      // Grant order with both queues continuously pending
      reset = 1;
      cyc(); cyc();
      reset = 0;
      for (int i = 0; i < 10; i++) begin
         hi_q.push_back(24'h040040);
         lo_q.push_back(24'h040040);
      end
      force_done = 1;
      ng = 0;
      for (int i = 0; i < 400 && ng < 10; i++) begin
         cyc();
         if (hi_ctrl_rd) begin order[ng] = 1; ng++; end
         else if (lo_ctrl_rd) begin order[ng] = 0; ng++; end
      end
      chk("t7_grant_count", ng, 10);
      for (int i = 0; i < 10; i++) begin
`ifdef STARVE_GUARD_EN
         chk("t7_grant_order", order[i], (i % 5) != 4);
`else
         chk("t7_grant_order", order[i], 1);
`endif
      end
      for (int i = 0; i < 1000; i++) begin
         cyc();
         if (hi_q.size() == 0 && lo_q.size() == 0 && !sched_busy) break;
      end
      force_done = 0;
      chk("t7_drained", hi_q.size() + lo_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/xmit_prio_sched.md
Name: xmit_prio_sched

Overview:
- Frame scheduler for the transmit path. Arbitrates between the high-priority and low-priority control-block queues and selects the next frame for the PHY transmitter.
- Pops one 24-bit control word per frame and validates its length. Valid frames get a start pulse; invalid frames are discarded.
- Enforces the inter-frame gap after each completed frame.
- Sits between the receive-side control FIFOs and the PHY serializer, entirely in the clk_sys domain.

Parameters:
- MAX_LEN, 12'd1518, largest legal frame length in bytes.
- MIN_LEN, 12'd64, smallest legal frame length in bytes.
- IFG_CYCLES, 12, clk_sys cycles of idle gap after tx_done; 0 means no gap.
- HI_BURST_MAX, 4, consecutive hi grants allowed before a pending lo frame is forced; used only with the optional feature.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- hi_ctrl_valid  in  1  hi control FIFO non-empty (show-ahead)
- hi_ctrl_in  in  24  hi control word at FIFO head
- hi_ctrl_rd  out  1  pop hi control FIFO
- lo_ctrl_valid  in  1  lo control FIFO non-empty (show-ahead)
- lo_ctrl_in  in  24  lo control word at FIFO head
- lo_ctrl_rd  out  1  pop lo control FIFO
- tx_done  in  1  one-cycle pulse from the transmitter when the last nibble has been sent
- tx_start  out  1  one-cycle pulse; starts the selected frame
- tx_sel  out  1  1 = hi queue, 0 = lo queue; held until the next grant
- tx_len  out  12  byte length of the granted frame; held with tx_sel
- discard_en  out  1  one-cycle pulse; the popped frame is dropped
- discard_sel  out  1  queue of the dropped frame
- sched_busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, active-high): state = IDLE. All outputs are 0, the latched control word is 0 and the hi-burst counter is 0.
- Control word format:
  - [11:0] = frame length in bytes.
  - [23:12] = length copy.
  - Example: 24'h200200 = 512 bytes, copy consistent.
- A frame is valid when [23:12] == [11:0] and MIN_LEN <= length <= MAX_LEN.
- State IDLE:
  - If any valid input is high, assert exactly one of hi_ctrl_rd / lo_ctrl_rd for one cycle.
  - Latch the corresponding ctrl_in word and the chosen queue, then go to CHECK.
  - Hi wins over lo whenever both are pending.
- State CHECK (exactly one cycle):
  - Valid frame: pulse tx_start, drive tx_sel and tx_len from the latch, go to XMIT.
  - Invalid frame: pulse discard_en with discard_sel = chosen queue, return to IDLE.
- Start latency: tx_start is asserted 2 cycles after the valid input rises while IDLE.
- State XMIT:
  - Wait for tx_done.
  - tx_done is ignored in every other state.
  - On tx_done, go to IFG if IFG_CYCLES > 0, otherwise go to IDLE.
- State IFG:
  - Counter loads IFG_CYCLES-1 on entry and decrements each cycle.
  - Go to IDLE in the cycle after the counter reaches 0.
  - Gap length = exactly IFG_CYCLES cycles with sched_busy = 1.
- Back-to-back operation:
  - A queue that stays pending is granted on the first IDLE cycle.
  - Minimum frame-to-frame spacing is tx_done → IFG_CYCLES → IDLE → CHECK → tx_start.
- Read pulses never occur outside IDLE; at most one pop per frame.
- A valid input that drops in the same cycle as the pop is still granted, because the word was latched that cycle.
- Reset asserted mid-frame: the FSM returns to IDLE immediately. No tx_start or discard_en is emitted, and the popped word is lost.

Optional Feature:
- Macro: STARVE_GUARD_EN.
- Defined:
  - An up-counter counts consecutive hi grants, saturating at HI_BURST_MAX.
  - In IDLE, when count == HI_BURST_MAX and lo_ctrl_valid = 1, lo is granted even if hi is pending.
  - Any lo grant clears the counter.
  - Discards count as grants.
- Not defined:
  - Strict priority: hi is always granted first.
  - No counter logic is synthesized.

Test Plan:
- Single lo frame, hi_ctrl_valid = 0, lo_ctrl_in = 24'h200200 → lo_ctrl_rd 1 cycle, then tx_start with tx_sel = 0, tx_len = 12'h200 two cycles later. Inject tx_done → sched_busy stays high for exactly 12 cycles, then falls.
- Both queues pending with valid words 24'h040040 → hi granted first (tx_sel = 1). After tx_done and IFG, lo is granted.
- Invalid words:
  - 24'h200100 (mismatched copy) → discard_en = 1, discard_sel matches the queue, no tx_start.
  - 24'h03F03F (63 bytes, below MIN_LEN) → same response.
  - 24'h7FF7FF (2047 bytes, above MAX_LEN) → same response.
  - In each case the FSM returns to IDLE.
- tx_done pulsed during IDLE and CHECK → ignored; the state machine still waits in XMIT for a later tx_done.
- Reset asserted 3 cycles into XMIT → all outputs are 0 the same cycle, the FSM is in IDLE, and the next pending frame is granted normally after reset is released.
- STARVE_GUARD_EN, HI_BURST_MAX = 4, hi and lo continuously pending → grant order hi, hi, hi, hi, lo, hi, hi, hi, hi, lo. Without the macro → all hi.
